// File: rtl/alu_fu_pipe_pkg.sv
// alu_fu_pipe_pkg: shared types and sizes for the ALU functional unit
package alu_fu_pipe_pkg;
    localparam int ALU_LAT = 3;
    localparam int ROB_W   = 5;
    localparam int PREG_W  = 7;
    localparam int XLEN    = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
    } alu_op_e;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_index;
        logic [PREG_W-1:0] pd;
    } rs_data;

    typedef struct packed {
        logic              valid;
        logic [ROB_W-1:0]  rob;
        logic [PREG_W-1:0] pd;
        logic [XLEN-1:0]   result;
    } alu_stage_t;
endpackage

// File: rtl/alu_fu_pipe_compute.sv
// alu_fu_pipe_compute: combinational ALU, (a, b, op) -> result; undefined ops give 0
module alu_fu_pipe_compute
    import alu_fu_pipe_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result
);
    logic [4:0] shamt;
    assign shamt = b[4:0];
    always_comb begin
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:   result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:  result = XLEN'(a < b);
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end
endmodule

// File: rtl/alu_fu_pipe.sv
// alu_fu_pipe: fixed-latency ALU functional unit with elastic stall chain
//   in : clk, reset (sync, active-low), alu_issued/rs_alu/alu_op/use_imm/imm/ps1_val/ps2_val
//        (issue), flush (kill in-flight), wb_grant (consumer takes completion)
//   out: fu_alu_ready, fu_alu_done, rob_fu_alu, p_alu_in, data_alu_in
module alu_fu_pipe
    import alu_fu_pipe_pkg::*;
#(
    parameter int LAT = ALU_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_issued,
    input  rs_data            rs_alu,
    input  alu_op_e           alu_op,
    input  logic              use_imm,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   ps1_val,
    input  logic [XLEN-1:0]   ps2_val,
    input  logic              flush,
    input  logic              wb_grant,
    output logic              fu_alu_ready,
    output logic              fu_alu_done,
    output logic [ROB_W-1:0]  rob_fu_alu,
    output logic [PREG_W-1:0] p_alu_in,
    output logic [XLEN-1:0]   data_alu_in
);
    alu_stage_t      st [LAT];
    alu_stage_t      s1_in;
    logic [LAT-1:0]  v;
    logic [LAT-1:0]  take;
    logic [XLEN-1:0] res;

    alu_fu_pipe_compute u_compute (
        .a      (ps1_val),
        .b      (use_imm ? imm : ps2_val),
        .op     (alu_op),
        .result (res)
    );

    // A stage can load iff the output is being granted or some stage at or
    // beyond it is empty: bubbles anywhere downstream let everything behind shift.
    genvar i;
    for (i = 0; i < LAT; i++) begin : g_take
        assign v[i]    = st[i].valid;
        assign take[i] = wb_grant || (v[LAT-1:i] != '1);
    end

    assign fu_alu_ready = take[0];
    assign s1_in = '{valid: alu_issued, rob: rs_alu.rob_index, pd: rs_alu.pd,
                     result: (rs_alu.pd == '0) ? '0 : res};

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int k = 0; k < LAT; k++) st[k] <= '0;
        end else begin
            if (take[0]) st[0] <= s1_in;
            for (int k = 1; k < LAT; k++) if (take[k]) st[k] <= st[k-1];
        end
    end

    assign fu_alu_done = st[LAT-1].valid;
    assign rob_fu_alu  = st[LAT-1].rob;
    assign p_alu_in    = st[LAT-1].pd;
    assign data_alu_in = st[LAT-1].result;

    a_issue_ready: assert property (@(posedge clk) disable iff (!reset) alu_issued |-> fu_alu_ready)
        else $error("alu_fu_pipe: issue while not ready");
endmodule

// File: tb/tb_alu_fu_pipe.sv
// tb_alu_fu_pipe: randomized scoreboard bench for alu_fu_pipe
module tb_alu_fu_pipe;
    import alu_fu_pipe_pkg::*;

    localparam int LAT = ALU_LAT;

    logic              clk = 0;
    logic              reset = 0;
    logic              alu_issued = 0;
    rs_data            rs_alu = '0;
    alu_op_e           alu_op = ALU_ADD;
    logic              use_imm = 0;
    logic [XLEN-1:0]   imm = '0;
    logic [XLEN-1:0]   ps1_val = '0;
    logic [XLEN-1:0]   ps2_val = '0;
    logic              flush = 0;
    logic              wb_grant = 1;
    logic              fu_alu_ready;
    logic              fu_alu_done;
    logic [ROB_W-1:0]  rob_fu_alu;
    logic [PREG_W-1:0] p_alu_in;
    logic [XLEN-1:0]   data_alu_in;

    always #5 clk = ~clk;

    alu_fu_pipe #(.LAT(LAT)) dut (
        .clk(clk), .reset(reset), .alu_issued(alu_issued), .rs_alu(rs_alu),
        .alu_op(alu_op), .use_imm(use_imm), .imm(imm), .ps1_val(ps1_val),
        .ps2_val(ps2_val), .flush(flush), .wb_grant(wb_grant),
        .fu_alu_ready(fu_alu_ready), .fu_alu_done(fu_alu_done),
        .rob_fu_alu(rob_fu_alu), .p_alu_in(p_alu_in), .data_alu_in(data_alu_in)
    );

    typedef struct {
        logic [ROB_W-1:0]  rob;
        logic [PREG_W-1:0] pd;
        logic [XLEN-1:0]   data;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference semantics of each operation written with plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a + (~b + 32'd1);
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << s;
            4'd6:    return a >> s;
            4'd7:    return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8:    return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            4'd9:    return {31'b0, a < b};
            4'd10:   return b;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: pops on every handshake, checks hold-stability while stalled.
    logic        held_v = 0;
    logic [43:0] held;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            q.delete();
            held_v = 0;
        end else begin
            if (held_v) chk("hold_stable", {fu_alu_done, rob_fu_alu, p_alu_in, data_alu_in}, {1'b1, held});
            held_v = 0;
            if (fu_alu_done && wb_grant) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {rob_fu_alu, p_alu_in, data_alu_in}, 64'hDEAD_0000_0000);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("completion", {rob_fu_alu, p_alu_in, data_alu_in}, {e.rob, e.pd, e.data});
                end
            end else if (fu_alu_done) begin
                held_v = 1;
                held = {rob_fu_alu, p_alu_in, data_alu_in};
            end
            if (flush) begin
                q.delete();
                held_v = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        alu_issued = 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ui, input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] pd,
                         output bit ok);
        exp_t e;
        #1;
        ok = fu_alu_ready;
        if (ok) begin
            alu_op  = alu_op_e'(op);
            ps1_val = a;
            use_imm = ui;
            imm     = ui ? b : $urandom;
            ps2_val = ui ? $urandom : b;
            rs_alu.rob_index = rob;
            rs_alu.pd        = pd;
            alu_issued = 1;
            e.rob  = rob;
            e.pd   = pd;
            e.data = (pd == 0) ? 32'h0 : ref_alu(op, a, b);
            q.push_back(e);
        end
    endtask

    task automatic rnd_issue(output bit ok);
        logic [31:0] b;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        issue(4'($urandom_range(0, 15)), $urandom, b, 1'($urandom_range(0, 1)),
              ROB_W'($urandom), ($urandom_range(0, 4) == 0) ? '0 : PREG_W'($urandom), ok);
    endtask

    // Call right after issue(); checks done rises exactly LAT edges after the issue edge.
    task automatic lat_check(input string nm);
        @(posedge clk);
        #1;
        alu_issued = 0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            chk(nm, fu_alu_done, (c == LAT) ? 1 : 0);
            if (c < LAT) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int c = 0; c < 60 && q.size() != 0; c++) begin
            @(negedge clk);
            #1;
        end
        chk(nm, q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        repeat (2) @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {fu_alu_done, rob_fu_alu, p_alu_in, data_alu_in}, '0);
            chk("reset_ready", fu_alu_ready, 1);
        end
        @(posedge clk);
        #1;
        reset = 1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_done", fu_alu_done, 0);
        end

        step();
        issue(4'd0, 32'd5, 32'd7, 0, 5'd3, 7'd40, ok);
        chk("add_ready", ok, 1);
        lat_check("add_latency");
        wait_drain("add_drain");

        step();
        issue(4'd1, 32'hFFFF_FFF0, 32'd4, 0, 5'd10, 7'd11, ok);
        step();
        issue(4'd8, 32'hFFFF_FFF0, 32'd4, 1, 5'd11, 7'd12, ok);
        step();
        issue(4'd7, 32'hFFFF_FFF0, 32'd4, 0, 5'd12, 7'd13, ok);
        step();
        repeat (3) begin
            @(negedge clk);
            chk("b2b_done", fu_alu_done, 1);
            step();
        end
        wait_drain("b2b_drain");

        step();
        wb_grant = 0;
        n = 0;
        repeat (10) begin
            rnd_issue(ok);
            if (ok) n++;
            step();
        end
        chk("fill_count", n, LAT);
        #1;
        chk("fill_ready", fu_alu_ready, 0);
        wb_grant = 1;
        wait_drain("stall_drain");

        step();
        issue(4'd0, 32'd1, 32'd1, 0, 5'd1, 7'd1, ok);
        step();
        issue(4'd2, 32'hF0, 32'h3C, 0, 5'd2, 7'd2, ok);
        step();
        flush = 1;
        step();
        flush = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("flushed_no_done", fu_alu_done, 0);
        end
        step();
        issue(4'd3, 32'hA0, 32'h0B, 1, 5'd4, 7'd9, ok);
        lat_check("post_flush_latency");
        wait_drain("post_flush_drain");

        step();
        issue(4'd0, 32'd100, 32'd23, 0, 5'd9, 7'd0, ok);
        lat_check("pd0_latency");
        wait_drain("pd0_drain");

        step();
        issue(4'd0, 32'd1, 32'd2, 0, 5'd4, 7'd5, ok);
        step();
        reset = 0;
        step();
        step();
        reset = 1;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("reset_mid_no_done", fu_alu_done, 0);
        end

        repeat (400) begin
            step();
            wb_grant = $urandom_range(0, 3) != 0;
            flush    = $urandom_range(0, 49) == 0;
            if ($urandom_range(0, 2) != 0) rnd_issue(ok);
        end
        step();
        flush = 0;
        wb_grant = 1;
        wait_drain("random_drain");

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
